// File: rtl/uart_alu_pkg.sv
// Shared types for the UART-controlled ALU endpoint: opcodes,
// interface FSM one-hot encodings and UART RX/TX state encodings.
package uart_alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [3:0] {
        ST_WAIT_A  = 4'b0001,
        ST_WAIT_B  = 4'b0010,
        ST_WAIT_OP = 4'b0100,
        ST_SEND    = 4'b1000
    } if_state_e;

    localparam int IDX_WAIT_A  = 0;
    localparam int IDX_WAIT_B  = 1;
    localparam int IDX_WAIT_OP = 2;
    localparam int IDX_SEND    = 3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_ARM,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_alu_top_core.sv
// uart_core: free-running baud tick generator plus 8N1 receiver
// (with start-bit glitch rejection) and 8N1 transmitter.
module uart_core
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA  = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 326
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rx_i,
    output logic               tx_o,
    output logic               rx_done_o,
    output logic [NB_DATA-1:0] rx_data_o,
    input  logic               tx_start_i,
    input  logic [NB_DATA-1:0] tx_data_i,
    output logic               tx_done_o
);

    localparam int NB_BAUD = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int NB_S    = $clog2(SB_TICK);
    localparam int NB_N    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [NB_BAUD-1:0] BAUD_LAST = NB_BAUD'(BAUD_DIV - 1);
    localparam logic [NB_S-1:0]    S_LAST    = NB_S'(SB_TICK - 1);
    localparam logic [NB_S-1:0]    S_HALF    = NB_S'(SB_TICK / 2 - 1);
    localparam logic [NB_N-1:0]    N_LAST    = NB_N'(NB_DATA - 1);

    logic [NB_BAUD-1:0] baud_q;
    logic               tick;

    assign tick = (baud_q == BAUD_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            baud_q <= '0;
        end else if (tick) begin
            baud_q <= '0;
        end else begin
            baud_q <= baud_q + 1'b1;
        end
    end

    rx_state_e          rx_st_q;
    logic [NB_S-1:0]    rx_s_q;
    logic [NB_N-1:0]    rx_n_q;
    logic [NB_DATA-1:0] rx_b_q;
    logic               rx_done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_st_q   <= RX_IDLE;
            rx_s_q    <= '0;
            rx_n_q    <= '0;
            rx_b_q    <= '0;
            rx_done_q <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            unique case (rx_st_q)
                RX_IDLE: begin
                    if (!rx_i) begin
                        rx_st_q <= RX_START;
                        rx_s_q  <= '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_s_q == S_HALF) begin
                            // line must still be low mid start bit
                            rx_st_q <= rx_i ? RX_IDLE : RX_DATA;
                            rx_s_q  <= '0;
                            rx_n_q  <= '0;
                        end else begin
                            rx_s_q <= rx_s_q + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (rx_s_q == S_LAST) begin
                            rx_s_q <= '0;
                            rx_b_q <= {rx_i, rx_b_q[NB_DATA-1:1]};
                            if (rx_n_q == N_LAST) begin
                                rx_st_q <= RX_STOP;
                            end else begin
                                rx_n_q <= rx_n_q + 1'b1;
                            end
                        end else begin
                            rx_s_q <= rx_s_q + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (rx_s_q == S_LAST) begin
                            rx_st_q   <= RX_IDLE;
                            rx_done_q <= rx_i;
                        end else begin
                            rx_s_q <= rx_s_q + 1'b1;
                        end
                    end
                end
                default: rx_st_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_done_o = rx_done_q;
    assign rx_data_o = rx_b_q;

    tx_state_e          tx_st_q;
    logic [NB_S-1:0]    tx_s_q;
    logic [NB_N-1:0]    tx_n_q;
    logic [NB_DATA-1:0] tx_b_q;
    logic               tx_q;
    logic               tx_done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_st_q   <= TX_IDLE;
            tx_s_q    <= '0;
            tx_n_q    <= '0;
            tx_b_q    <= '0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            unique case (tx_st_q)
                TX_IDLE: begin
                    if (tx_start_i) begin
                        tx_st_q <= TX_ARM;
                        tx_b_q  <= tx_data_i;
                        tx_s_q  <= '0;
                    end
                end
                TX_ARM: begin
                    // align the start bit to a tick boundary
                    if (tick) begin
                        tx_st_q <= TX_START;
                        tx_q    <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        if (tx_s_q == S_LAST) begin
                            tx_st_q <= TX_DATA;
                            tx_s_q  <= '0;
                            tx_n_q  <= '0;
                            tx_q    <= tx_b_q[0];
                        end else begin
                            tx_s_q <= tx_s_q + 1'b1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (tx_s_q == S_LAST) begin
                            tx_s_q <= '0;
                            tx_b_q <= tx_b_q >> 1;
                            if (tx_n_q == N_LAST) begin
                                tx_st_q <= TX_STOP;
                                tx_q    <= 1'b1;
                            end else begin
                                tx_n_q <= tx_n_q + 1'b1;
                                tx_q   <= tx_b_q[1];
                            end
                        end else begin
                            tx_s_q <= tx_s_q + 1'b1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (tx_s_q == S_LAST) begin
                            tx_st_q   <= TX_IDLE;
                            tx_done_q <= 1'b1;
                        end else begin
                            tx_s_q <= tx_s_q + 1'b1;
                        end
                    end
                end
                default: tx_st_q <= TX_IDLE;
            endcase
        end
    end

    assign tx_o      = tx_q;
    assign tx_done_o = tx_done_q;

endmodule

// File: rtl/uart_alu_top.sv
// UART ALU endpoint: collects A, B, opcode bytes, returns one result byte.
// Define UART_ALU_RX_SYNC_EN to put a two-flop synchronizer on i_rx.
module uart_alu_top
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA  = 8,
    parameter int NB_CODE  = 6,
    parameter int SB_TICK  = 16,
    parameter int NB_STATE = 4,
    parameter int BAUD_DIV = 326
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_rx,
    output logic o_tx
);

    logic rx_in;

`ifdef UART_ALU_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_rx};
        end
    end

    assign rx_in = sync_q[1];
`else
    assign rx_in = i_rx;
`endif

    logic               rx_done;
    logic [NB_DATA-1:0] rx_data;
    logic               tx_done;

    logic [NB_STATE-1:0] state_q;
    logic [NB_DATA-1:0]  a_q;
    logic [NB_DATA-1:0]  b_q;
    logic [NB_CODE-1:0]  op_q;
    logic [NB_DATA-1:0]  res_q;
    logic                tx_start_q;

    uart_core #(
        .NB_DATA (NB_DATA),
        .SB_TICK (SB_TICK),
        .BAUD_DIV(BAUD_DIV)
    ) u_core (
        .clk_i     (i_clk),
        .rst_ni    (i_reset),
        .rx_i      (rx_in),
        .tx_o      (o_tx),
        .rx_done_o (rx_done),
        .rx_data_o (rx_data),
        .tx_start_i(tx_start_q),
        .tx_data_i (res_q),
        .tx_done_o (tx_done)
    );

    logic [NB_CODE-1:0] op_sel;
    logic [NB_DATA-1:0] alu_res;

    // the opcode byte feeds the ALU directly so the result registers with it
    always_comb begin
        op_sel = op_q;
        if (state_q[IDX_WAIT_OP] && rx_done) begin
            op_sel = rx_data[NB_CODE-1:0];
        end
        alu_res = '0;
        unique case (op_sel)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_SRA:  alu_res = $signed(a_q) >>> b_q;
            OP_SRL:  alu_res = a_q >> b_q;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= NB_STATE'(ST_WAIT_A);
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (1'b1)
                state_q[IDX_WAIT_A]: begin
                    if (rx_done) begin
                        a_q     <= rx_data;
                        state_q <= NB_STATE'(ST_WAIT_B);
                    end
                end
                state_q[IDX_WAIT_B]: begin
                    if (rx_done) begin
                        b_q     <= rx_data;
                        state_q <= NB_STATE'(ST_WAIT_OP);
                    end
                end
                state_q[IDX_WAIT_OP]: begin
                    if (rx_done) begin
                        op_q       <= op_sel;
                        res_q      <= alu_res;
                        tx_start_q <= 1'b1;
                        state_q    <= NB_STATE'(ST_SEND);
                    end
                end
                state_q[IDX_SEND]: begin
                    if (tx_done) begin
                        state_q <= NB_STATE'(ST_WAIT_A);
                    end
                end
                default: state_q <= NB_STATE'(ST_WAIT_A);
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_top.sv
// Bench for uart_alu_top: serial byte driver, o_tx frame monitor
// and an expected-result queue checked as frames come back.
module tb_uart_alu_top;

    localparam int BAUD = 4;
    localparam int SBT  = 16;
    localparam int BIT  = BAUD * SBT;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] e;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic tx;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [8:0] got_q[$];

    uart_alu_top #(
        .NB_DATA (8),
        .NB_CODE (6),
        .SB_TICK (SBT),
        .NB_STATE(4),
        .BAUD_DIV(BAUD)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .i_rx   (rx),
        .o_tx   (tx)
    );

    always #5 clk = ~clk;

    always begin : mon
        logic [7:0] d;
        logic       s;
        @(negedge clk);
        if (rst_n && tx === 1'b0) begin
            d = '0;
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                d[i] = tx;
            end
            repeat (BIT) @(negedge clk);
            s = tx;
            got_q.push_back({s, d});
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit bad_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (bad_stop) begin
            rx = 1'b0;
            repeat (10 * BAUD) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_triple(input vec_t v, input bit push);
        send_byte(v.a, 1'b0);
        send_byte(v.b, 1'b0);
        send_byte(v.op, 1'b0);
        if (push) exp_q.push_back(v.e);
    endtask

    task automatic get_frame(output bit ok, output logic [8:0] g,
                             output logic [8:0] e);
        ok = 1'b0;
        g  = '0;
        e  = '0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (got_q.size() > 0) ok = 1'b1;
        end
        if (ok) g = got_q.pop_front();
        if (exp_q.size() > 0) e = {1'b1, exp_q.pop_front()};
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            $display("FAIL reset_tx got=%b exp=1", tx);
            failures++;
        end
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            $display("FAIL idle_tx got=%b exp=1", tx);
            failures++;
        end
        checks++;
        if (got_q.size() != 0) begin
            $display("FAIL idle_frames got=%0d exp=0", got_q.size());
            failures++;
        end
    endtask

    task automatic test_alu();
        vec_t vecs[$];
        bit ok;
        logic [8:0] g, e;
        vecs.push_back({8'h03, 8'h08, 8'h20, 8'h0B});
        vecs.push_back({8'h03, 8'h08, 8'h22, 8'hFB});
        vecs.push_back({8'hF0, 8'h04, 8'h03, 8'hFF});
        vecs.push_back({8'hF0, 8'h04, 8'h02, 8'h0F});
        vecs.push_back({8'hC3, 8'h5A, 8'h24, 8'h42});
        vecs.push_back({8'hC3, 8'h5A, 8'h25, 8'hDB});
        vecs.push_back({8'hC3, 8'h5A, 8'h26, 8'h99});
        vecs.push_back({8'hC3, 8'h5A, 8'h27, 8'h24});
        vecs.push_back({8'hFF, 8'h02, 8'h20, 8'h01});
        vecs.push_back({8'h10, 8'h20, 8'hE0, 8'h30});
        foreach (vecs[k]) begin
            send_triple(vecs[k], 1'b1);
            get_frame(ok, g, e);
            checks++;
            if (!ok || g !== e) begin
                $display("FAIL alu_%0d op=%h got=%h exp=%h ok=%0d",
                         k, vecs[k].op, g, e, ok);
                failures++;
            end
            if (k == 0) begin
                repeat (1500) @(negedge clk);
                checks++;
                if (got_q.size() != 0) begin
                    $display("FAIL extra_frames got=%0d exp=0",
                             got_q.size());
                    failures++;
                end
            end
        end
    endtask

    task automatic test_undef();
        bit ok;
        logic [8:0] g, e;
        send_triple({8'h55, 8'hAA, 8'h3F, 8'h00}, 1'b1);
        get_frame(ok, g, e);
        checks++;
        if (!ok || g !== e) begin
            $display("FAIL undef got=%h exp=%h ok=%0d", g, e, ok);
            failures++;
        end
        send_triple({8'h03, 8'h08, 8'h20, 8'h0B}, 1'b1);
        get_frame(ok, g, e);
        checks++;
        if (!ok || g !== e) begin
            $display("FAIL after_undef got=%h exp=%h ok=%0d", g, e, ok);
            failures++;
        end
    endtask

    task automatic test_glitch();
        bit ok;
        logic [8:0] g, e;
        @(negedge clk);
        rx = 1'b0;
        repeat (3 * BAUD) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        checks++;
        if (got_q.size() != 0) begin
            $display("FAIL glitch_frames got=%0d exp=0", got_q.size());
            failures++;
        end
        send_triple({8'h03, 8'h08, 8'h20, 8'h0B}, 1'b1);
        get_frame(ok, g, e);
        checks++;
        if (!ok || g !== e) begin
            $display("FAIL glitch got=%h exp=%h ok=%0d", g, e, ok);
            failures++;
        end
    endtask

    task automatic test_bad_stop();
        bit ok;
        logic [8:0] g, e;
        send_byte(8'h77, 1'b1);
        send_triple({8'h01, 8'h02, 8'h20, 8'h03}, 1'b1);
        get_frame(ok, g, e);
        checks++;
        if (!ok || g !== e) begin
            $display("FAIL bad_stop got=%h exp=%h ok=%0d", g, e, ok);
            failures++;
        end
    endtask

    task automatic test_reset_mid_rx();
        bit ok;
        logic [8:0] g, e;
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            $display("FAIL rst_rx_tx got=%b exp=1", tx);
            failures++;
        end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (BIT) @(negedge clk);
        send_triple({8'h03, 8'h08, 8'h20, 8'h0B}, 1'b1);
        get_frame(ok, g, e);
        checks++;
        if (!ok || g !== e) begin
            $display("FAIL rst_rx_result got=%h exp=%h ok=%0d", g, e, ok);
            failures++;
        end
    endtask

    task automatic test_reset_mid_tx();
        bit seen;
        send_triple({8'h03, 8'h08, 8'h20, 8'h0B}, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            $display("FAIL rst_tx_start got=none exp=start_bit");
            failures++;
        end
        repeat (3 * BIT) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            $display("FAIL rst_tx_abort got=%b exp=1", tx);
            failures++;
        end
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (800) @(negedge clk);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_undef();
        test_glitch();
        test_bad_stop();
        test_reset_mid_rx();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_alu_top.md
# uart_alu_top

UART-controlled ALU endpoint: receives operand A, operand B and an opcode as three consecutive 8N1 serial bytes on `i_rx`, computes the ALU result, and transmits it as one 8N1 byte on `o_tx`. Sits at the FPGA pin boundary of the ALU lab design; 50 MHz system clock, 9600 baud, 16× oversampling.

## Interface
- `NB_DATA`, 8: data/operand/result width and UART payload bits.
- `NB_CODE`, 6: opcode width (low 6 bits of the third received byte).
- `SB_TICK`, 16: oversampling ticks per bit (stop bit = `SB_TICK` ticks).
- `NB_STATE`, 4: width of the one-hot interface FSM state register.
- `BAUD_DIV`, 326: system clocks per oversampling tick (50 MHz / (9600·16)).
- `i_clk`  in  1  system clock, all logic on rising edge.
- `i_reset`  in  1  reset; one clock; reset is asynchronous and active-low.
- `i_rx`  in  1  serial input, idle high.
- `o_tx`  out  1  serial output, idle high; reset value 1.

## Operation
- Baud generator: counter 0..`BAUD_DIV`-1, one-cycle `tick` pulse on wrap; free-running.
- RX: idle until `i_rx` low; count `SB_TICK/2-1` ticks; if `i_rx` still low, start confirmed, else back to idle (glitch rejection). Then `NB_DATA` bits, each sampled after `SB_TICK` ticks, LSB first; stop bit sampled after `SB_TICK` ticks. Stop=1 → one-cycle `rx_done` with byte; stop=0 → byte discarded, no `rx_done`.
- Interface FSM, one-hot: `WAIT_A`(0001) → `WAIT_B`(0010) → `WAIT_OP`(0100) → `SEND`(1000) → `WAIT_A`. Each `rx_done` latches the byte into A, B, or opcode (low `NB_CODE` bits) and advances. Entering `SEND` pulses `tx_start` for one cycle with the registered result; FSM leaves `SEND` on `tx_done`. Bytes arriving during `SEND` are dropped.
- ALU (combinational, `NB_DATA` wide, carries discarded): 100000 ADD A+B; 100010 SUB A−B (two's complement wrap); 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 000011 SRA A>>>B; 000010 SRL A>>B. Any other opcode → 0x00.
- TX: on `tx_start` while idle, send start bit (0), `NB_DATA` data bits LSB first, stop bit (1), each `SB_TICK` ticks; one-cycle `tx_done` at end of stop bit. `tx_start` while busy ignored.

## Timing
- Reset: FSM `WAIT_A`, A/B/opcode/result = 0, RX/TX idle, baud counter 0, `o_tx`=1. Reset mid-frame aborts RX and TX immediately; `o_tx` returns to 1.
- Opcode `rx_done` at cycle n → result registered and `tx_start` at n+1; start bit driven on the first `tick` after n+1.
- One frame = 10 bits × `SB_TICK` × `BAUD_DIV` clocks ≈ 52 160 clocks (≈1.043 ms).
- `rx_done` and `tx_done` are exactly one clock wide.

## Configuration
- `UART_ALU_RX_SYNC_EN` defined: `i_rx` passes a two-flop synchronizer (reset to 1) before the RX FSM; adds 2 clocks of input latency.
- Undefined: `i_rx` feeds the RX FSM directly (for synchronous simulation and externally synchronized inputs).

## Structure
- Package `uart_alu_pkg`: opcode constants, one-hot FSM state encodings, RX/TX state encodings.
- One sub-module `uart_core`: baud generator, RX and TX, exposing `rx_done`/`rx_data`/`tx_start`/`tx_data`/`tx_done`; the top holds the interface FSM and ALU.

## Test plan
- Send 0x03, 0x08, 0x20 (ADD) ≈1.05 ms apart → one frame on `o_tx` carrying 0x0B; no further frames.
- Send 0x03, 0x08, 0x22 (SUB) → 0xFB; 0xF0, 0x04, 0x03 (SRA) → 0xFF; 0xF0, 0x04, 0x02 (SRL) → 0x0F.
- Send 0x55, 0xAA, 0x3F (undefined opcode) → 0x00 transmitted, FSM back to `WAIT_A`.
- 3-tick low glitch on `i_rx`, then 0x03, 0x08, 0x20 → no spurious byte; result 0x0B.
- Frame with stop bit 0 as operand A → discarded; next three valid bytes 0x01, 0x02, 0x20 → 0x03.
- Assert reset mid-way through A's frame, release, send 0x03, 0x08, 0x20 → `o_tx` high during reset, then 0x0B.
